// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, port owner, request bundle.
// Defaults for the starvation bound and read return latency live here too.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_CPU = 2'd1,
        LOCK_GFX = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_GFX  = 2'd2
    } owner_t;

    localparam int unsigned STARVE_LIMIT_DEF = 8;
    localparam int unsigned READ_LATENCY_DEF = 1;

    // One access as presented on the memory port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
        logic        re;
    } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between CPU memory stage, graphics bypass writer, memory port and the arbiter.
// Perf counter signals exist only when ARB_PERF_CNT_EN is defined.
interface dmem_port_arbiter_if;

    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic        cpu_stall;
    logic [31:0] cpu_dout;
    logic        cpu_rvalid;

    logic        gfx_req;
    logic [31:0] gfx_addr;
    logic [3:0]  gfx_we;
    logic [31:0] gfx_din;
    logic        gfx_ack;

    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ready;

`ifdef ARB_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_cpu_stall_cycles;
    logic [31:0] perf_gfx_grants;
`endif

    // Requesters and memory model side.
    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_din,
        output gfx_req, gfx_addr, gfx_we, gfx_din,
        output mem_dout, mem_ready,
`ifdef ARB_PERF_CNT_EN
        output perf_clr,
        input  perf_cpu_stall_cycles, perf_gfx_grants,
`endif
        input  cpu_stall, cpu_dout, cpu_rvalid, gfx_ack,
        input  mem_addr, mem_we, mem_re, mem_din
    );

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_din,
        input  gfx_req, gfx_addr, gfx_we, gfx_din,
        input  mem_dout, mem_ready,
`ifdef ARB_PERF_CNT_EN
        input  perf_clr,
        output perf_cpu_stall_cycles, perf_gfx_grants,
`endif
        output cpu_stall, cpu_dout, cpu_rvalid, gfx_ack,
        output mem_addr, mem_we, mem_re, mem_din
    );

endinterface

// File: rtl/dmem_port_arbiter_read_tracker.sv
// Read-return tracker: delays each accepted CPU read by READ_LATENCY cycles, then captures mem_dout.
// Latency READ_LATENCY cycles; no backpressure (reads are always returned).
// cpu_dout passes mem_dout through on the return cycle and holds the captured value otherwise.
module arb_read_tracker #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_accept,
    input  logic [31:0] mem_dout,
    output logic [31:0] cpu_dout,
    output logic        cpu_rvalid
);

    logic [READ_LATENCY-1:0] pipe_q;
    logic [31:0]             dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= rd_accept;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign cpu_rvalid = pipe_q[READ_LATENCY-1];
    assign cpu_dout   = cpu_rvalid ? mem_dout : dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (cpu_rvalid) begin
            dout_q <= mem_dout;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between CPU load/store and graphics bypass writes; optional ARB_PERF_CNT_EN perf counters.
// Grant is combinational (zero latency when uncontended); CPU read data returns READ_LATENCY cycles after accept.
// mem_ready low locks the port to its owner with stable outputs; CPU stalls until accepted, gfx waits for gfx_ack.
module dmem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t  state_q, state_d;
    owner_t      owner;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    mem_req_t    hold_q, drive;
    logic        accept;
    logic        gfx_accept;
    logic        cpu_rd_accept;

    // Owner selection, port drive and next state. Everything is gated by rst so the
    // port and handshakes read as idle for the whole reset window.
    always_comb begin
        owner         = OWN_NONE;
        drive         = hold_q;
        drive.we      = 4'd0;
        drive.re      = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        accept        = 1'b0;
        gfx_accept    = 1'b0;
        cpu_rd_accept = 1'b0;

        if (rst) begin
            case (state_q)
                LOCK_CPU: owner = OWN_CPU;
                LOCK_GFX: owner = OWN_GFX;
                default: begin
                    if (bus.gfx_req && wait_cnt_q == LIMIT) owner = OWN_GFX;
                    else if (bus.cpu_req)                   owner = OWN_CPU;
                    else if (bus.gfx_req)                   owner = OWN_GFX;
                    else                                    owner = OWN_NONE;
                end
            endcase
        end

        // A locked owner replays the captured request so the port cannot glitch.
        if (state_q != IDLE) begin
            drive = hold_q;
        end else if (owner == OWN_CPU) begin
            drive = '{addr: bus.cpu_addr, din: bus.cpu_din, we: bus.cpu_we,
                      re: (bus.cpu_we == 4'd0)};
        end else if (owner == OWN_GFX) begin
            drive = '{addr: bus.gfx_addr, din: bus.gfx_din, we: bus.gfx_we, re: 1'b0};
        end

        accept        = (owner != OWN_NONE) && bus.mem_ready;
        gfx_accept    = accept && (owner == OWN_GFX);
        cpu_rd_accept = accept && (owner == OWN_CPU) && drive.re;

        if (accept) begin
            state_d = IDLE;
        end else if (owner == OWN_CPU) begin
            state_d = LOCK_CPU;
        end else if (owner == OWN_GFX) begin
            state_d = LOCK_GFX;
        end

        if (!bus.gfx_req || gfx_accept) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            // Capture on every fresh grant; this is both the lock snapshot and the idle hold value.
            if (state_q == IDLE && owner != OWN_NONE) begin
                hold_q <= drive;
            end
        end
    end

    assign bus.mem_addr  = drive.addr;
    assign bus.mem_din   = drive.din;
    assign bus.mem_we    = drive.we;
    assign bus.mem_re    = drive.re;
    assign bus.gfx_ack   = gfx_accept;
    assign bus.cpu_stall = rst && bus.cpu_req && !(owner == OWN_CPU && bus.mem_ready);

    arb_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_tracker (
        .clk        (clk),
        .rst        (rst),
        .rd_accept  (cpu_rd_accept),
        .mem_dout   (bus.mem_dout),
        .cpu_dout   (bus.cpu_dout),
        .cpu_rvalid (bus.cpu_rvalid)
    );

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_grant_q <= '0;
        end else if (bus.perf_clr) begin
            perf_stall_q <= '0;
            perf_grant_q <= '0;
        end else begin
            if (bus.cpu_stall) perf_stall_q <= perf_stall_q + 32'd1;
            if (gfx_accept)    perf_grant_q <= perf_grant_q + 32'd1;
        end
    end

    assign bus.perf_cpu_stall_cycles = perf_stall_q;
    assign bus.perf_gfx_grants       = perf_grant_q;
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (dcache_addr/we/re/din/dout) between the CPU load/store path and the graphics bypass writer.
- Sits between the datapath's memory stage, the graphics bypass ports and the memory system.
- Stalls the CPU while it lacks the port; bounds graphics starvation with a wait counter.
- Returns CPU read data with fixed latency.

Parameters:
STARVE_LIMIT, 8, cycles a pending gfx request may wait before it beats the CPU (1..255)
READ_LATENCY, 1, cycles from accepted read to mem_dout valid (1..4)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (clk single clock domain)
cpu_req  in  1  CPU memory access request (load or store)
cpu_addr  in  32  CPU byte address
cpu_we  in  4  CPU byte write enables; 0 means read
cpu_din  in  32  CPU store data
cpu_stall  out  1  CPU must hold request and freeze pipeline
cpu_dout  out  32  CPU read data
cpu_rvalid  out  1  cpu_dout valid this cycle
gfx_req  in  1  graphics bypass write request
gfx_addr  in  32  graphics byte address
gfx_we  in  4  graphics byte enables (write-only requester)
gfx_din  in  32  graphics write data
gfx_ack  out  1  graphics write accepted this cycle
mem_addr  out  32  to memory port
mem_we  out  4  to memory port
mem_re  out  1  to memory port
mem_din  out  32  to memory port
mem_dout  in  32  from memory port
mem_ready  in  1  memory accepts the presented access this cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, wait_cnt=0, read pipe cleared. Outputs: cpu_stall=0, cpu_rvalid=0, cpu_dout=0, gfx_ack=0, mem_we=0, mem_re=0, mem_addr=0, mem_din=0. Reset mid-transaction abandons it; no ack or rvalid is produced afterwards.
- FSM states: IDLE, LOCK_CPU, LOCK_GFX.
- IDLE owner selection (combinational): gfx if gfx_req && wait_cnt==STARVE_LIMIT; else cpu if cpu_req; else gfx if gfx_req; else none.
- LOCK_x: owner is x; no re-arbitration.
- Port drive: owner's addr/din/we go to the mem outputs. mem_re=1 only for a CPU owner with cpu_we==0. No owner: mem_we=0, mem_re=0, addr/din hold last value.
- Accept = owner present && mem_ready=1. Accept in any state returns to IDLE.
- Owner present but mem_ready=0: go to (or stay in) LOCK_owner; port outputs stay stable until accept.
- cpu_stall = cpu_req && !(owner==cpu && mem_ready). Combinational; zero-latency grant when uncontended.
- gfx_ack: 1 in the gfx accept cycle. gfx_we==0 is accepted and acked with mem_we=0 (no-op).
- Reads: an accepted CPU read pushes a token into a READ_LATENCY-deep shift register. When the token exits: cpu_rvalid=1 and cpu_dout=mem_dout sampled that cycle. cpu_dout holds between reads. Back-to-back reads give back-to-back rvalids.
- wait_cnt (8-bit): +1 each cycle gfx_req=1 without gfx accept, saturating at STARVE_LIMIT. Cleared on gfx accept or gfx_req=0.
- Simultaneous cpu_req and gfx_req with wait_cnt<STARVE_LIMIT: CPU wins.

Optional Feature:
- ARB_PERF_CNT_EN defined adds:
  - input perf_clr: synchronous clear.
  - output perf_cpu_stall_cycles (32): counts cycles with cpu_stall=1.
  - output perf_gfx_grants (32): counts gfx accepts.
  - Both counters wrap at 2^32 and reset to 0 on rst.
- Without the macro: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_arb_pkg: FSM state encoding (IDLE=2'd0, LOCK_CPU=2'd1, LOCK_GFX=2'd2), owner encoding (NONE, CPU, GFX), default STARVE_LIMIT.
- One sub-module: arb_read_tracker. Holds the READ_LATENCY token shift register and the cpu_dout/cpu_rvalid capture.

Test Plan:
1. CPU-only: read 0x100 with mem_ready=1, READ_LATENCY=1, mem_dout=0xDEADBEEF next cycle -> no stall, mem_re=1, cpu_rvalid=1 one cycle later with cpu_dout=0xDEADBEEF.
2. Contention: cpu_req and gfx_req held continuously, STARVE_LIMIT=8 -> CPU accepted cycles 0-7, gfx_ack at cycle 8 with cpu_stall=1 that cycle, wait_cnt back to 0.
3. Memory stall: gfx write 0x2000/0xFF00FF00, mem_ready=0 for 3 cycles -> LOCK_GFX, mem outputs stable, cpu_req arriving meanwhile stalls, gfx_ack on 4th cycle, CPU served next.
4. Reset mid-read: assert rst between the CPU read accept and its rvalid -> outputs zero immediately, no cpu_rvalid after release.
5. gfx_we=0 request -> gfx_ack same cycle, mem_we=0, mem_re=0.
6. ARB_PERF_CNT_EN: scenario 2 -> perf_gfx_grants=1, perf_cpu_stall_cycles=1; perf_clr -> both 0.
